// File: rtl/vend_dispense_ctrl_if.sv
// Coin-FSM to vend-controller signal bundle; refund exists only with VEND_REFUND_EN.
// master drives requests/sensors, slave is the dispense controller.
interface vend_dispense_ctrl_if #(
  parameter int CREDIT_W = 3
);
  logic                can_despatch;
  logic                drop_sensor;
  logic                refill;
  logic                fault_clr;
  logic                motor_on;
  logic                item_out;
  logic                fault;
  logic                stock_empty;
  logic [7:0]          stock_count;
  logic [CREDIT_W-1:0] pending;
`ifdef VEND_REFUND_EN
  logic                refund;

  modport master (
    output can_despatch, drop_sensor, refill, fault_clr,
    input  motor_on, item_out, fault, stock_empty, stock_count, pending, refund
  );
  modport slave (
    input  can_despatch, drop_sensor, refill, fault_clr,
    output motor_on, item_out, fault, stock_empty, stock_count, pending, refund
  );
`else
  modport master (
    output can_despatch, drop_sensor, refill, fault_clr,
    input  motor_on, item_out, fault, stock_empty, stock_count, pending
  );
  modport slave (
    input  can_despatch, drop_sensor, refill, fault_clr,
    output motor_on, item_out, fault, stock_empty, stock_count, pending
  );
`endif
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Vend dispense controller: queues despatch requests, runs motor, awaits drop, tracks stock/faults.
// Motor starts 2 cycles after a request; requests beyond 2^CREDIT_W-1 queued are dropped. Option: VEND_REFUND_EN.
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 16,
  parameter int STOCK_INIT   = 10,
  parameter int CREDIT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  vend_dispense_ctrl_if.slave   vif
);

  localparam int MT_W = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
  localparam int DT_W = (DROP_TIMEOUT > 1) ? $clog2(DROP_TIMEOUT) : 1;
  localparam logic [MT_W-1:0]     MOTOR_LOAD = MT_W'(MOTOR_CYCLES - 1);
  localparam logic [DT_W-1:0]     DROP_LOAD  = DT_W'(DROP_TIMEOUT - 1);
  localparam logic [CREDIT_W-1:0] PEND_MAX   = '1;
  localparam logic [7:0]          STOCK_RST  = 8'(STOCK_INIT);

  typedef enum logic [2:0] {
    IDLE,
    MOTOR,
    WAIT_DROP,
    DONE,
    FAULT
  } state_t;

  state_t              state_q;
  logic                can_q;
  logic                motor_q;
  logic                item_q;
  logic                fault_q;
  logic [MT_W-1:0]     mtmr_q;
  logic [DT_W-1:0]     dtmr_q;
  logic [CREDIT_W-1:0] pend_q, pend_d;
  logic [7:0]          stock_q, stock_d;
`ifdef VEND_REFUND_EN
  logic                refund_q;
`endif

  logic req, pend_inc, pend_dec;

  assign req      = vif.can_despatch & ~can_q;
  assign pend_inc = req & (pend_q != PEND_MAX);
  // IDLE consumes one request per cycle, either to vend or to discard when empty
  assign pend_dec = (state_q == IDLE) & (pend_q != '0);

  always_comb begin
    pend_d = pend_q;
    if (pend_inc && !pend_dec) begin
      pend_d = pend_q + CREDIT_W'(1);
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - CREDIT_W'(1);
    end
  end

  always_comb begin
    stock_d = stock_q;
    if (vif.refill) begin
      stock_d = STOCK_RST;
    end else if (state_q == DONE && stock_q != 8'd0) begin
      stock_d = stock_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      can_q    <= 1'b0;
      motor_q  <= 1'b0;
      item_q   <= 1'b0;
      fault_q  <= 1'b0;
      mtmr_q   <= '0;
      dtmr_q   <= '0;
      pend_q   <= '0;
      stock_q  <= STOCK_RST;
`ifdef VEND_REFUND_EN
      refund_q <= 1'b0;
`endif
    end else begin
      can_q    <= vif.can_despatch;
      pend_q   <= pend_d;
      stock_q  <= stock_d;
      item_q   <= 1'b0;
`ifdef VEND_REFUND_EN
      refund_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pend_q != '0) begin
            if (stock_q != 8'd0) begin
              state_q <= MOTOR;
              motor_q <= 1'b1;
              mtmr_q  <= MOTOR_LOAD;
            end else begin
`ifdef VEND_REFUND_EN
              refund_q <= 1'b1;
`endif
            end
          end
        end
        MOTOR: begin
          if (mtmr_q == '0) begin
            state_q <= WAIT_DROP;
            motor_q <= 1'b0;
            dtmr_q  <= DROP_LOAD;
          end else begin
            mtmr_q <= mtmr_q - MT_W'(1);
          end
        end
        WAIT_DROP: begin
          // a drop on the final timeout cycle still counts as a successful vend
          if (vif.drop_sensor) begin
            state_q <= DONE;
            item_q  <= 1'b1;
          end else if (dtmr_q == '0) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else begin
            dtmr_q <= dtmr_q - DT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        FAULT: begin
          if (vif.fault_clr) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          motor_q <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign vif.motor_on    = motor_q;
  assign vif.item_out    = item_q;
  assign vif.fault       = fault_q;
  assign vif.stock_count = stock_q;
  assign vif.stock_empty = (stock_q == 8'd0);
  assign vif.pending     = pend_q;
`ifdef VEND_REFUND_EN
  assign vif.refund      = refund_q;
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl at default parameters (MOTOR 8, DROP 16, STOCK 10, CREDIT_W 3).
module tb_vend_dispense_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  vend_dispense_ctrl_if #(.CREDIT_W(3)) vif ();

  vend_dispense_ctrl #(
    .MOTOR_CYCLES(8),
    .DROP_TIMEOUT(16),
    .STOCK_INIT  (10),
    .CREDIT_W    (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    vif.can_despatch = 1'b0;
    vif.drop_sensor  = 1'b0;
    vif.refill       = 1'b0;
    vif.fault_clr    = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int on_cnt, first_on, items, peak, it1, it2, fall_i, rise_i, ref_cnt;
    logic prev_motor, prev_fault;
    n_cmp = 0;
    n_err = 0;

    // reset state
    do_reset();
    check("rst_motor", 32'(vif.motor_on), 0);
    check("rst_item", 32'(vif.item_out), 0);
    check("rst_fault", 32'(vif.fault), 0);
    check("rst_pending", 32'(vif.pending), 0);
    check("rst_stock", 32'(vif.stock_count), 10);
    check("rst_empty", 32'(vif.stock_empty), 0);
`ifdef VEND_REFUND_EN
    check("rst_refund", 32'(vif.refund), 0);
`endif

    // single vend, drop 3 cycles after motor stops
    on_cnt = 0; first_on = -1; items = 0;
    for (int i = 0; i < 14; i++) begin
      vif.can_despatch = (i == 0);
      vif.drop_sensor  = (i == 12);
      tick();
      if (i == 0) check("v1_pending_after_req", 32'(vif.pending), 1);
      if (vif.motor_on) begin
        on_cnt++;
        if (first_on < 0) first_on = i;
      end
      if (vif.item_out) items++;
      if (i == 12) check("v1_stock_during_done", 32'(vif.stock_count), 10);
    end
    vif.drop_sensor = 1'b0;
    check("v1_motor_cycles", 32'(on_cnt), 8);
    check("v1_motor_start", 32'(first_on), 1);
    check("v1_items", 32'(items), 1);
    check("v1_stock", 32'(vif.stock_count), 9);
    check("v1_pending", 32'(vif.pending), 0);

    // three spaced requests, prompt drop -> back-to-back vends
    do_reset();
    vif.drop_sensor = 1'b1;
    items = 0; peak = 0; it1 = -1; it2 = -1;
    for (int i = 0; i < 40; i++) begin
      vif.can_despatch = (i == 0 || i == 2 || i == 4);
      tick();
      if (int'(vif.pending) > peak) peak = int'(vif.pending);
      if (vif.item_out) begin
        items++;
        if (it1 < 0) it1 = i;
        else if (it2 < 0) it2 = i;
      end
    end
    vif.drop_sensor = 1'b0;
    check("v3_peak_pending", 32'(peak), 2);
    check("v3_items", 32'(items), 3);
    check("v3_item_gap", 32'(it2 - it1), 11);
    check("v3_stock", 32'(vif.stock_count), 7);
    check("v3_pending", 32'(vif.pending), 0);

    // drop never arrives -> fault 16 cycles after motor stops
    do_reset();
    fall_i = -1; rise_i = -1; prev_motor = 1'b0; prev_fault = 1'b0;
    for (int i = 0; i < 40; i++) begin
      vif.can_despatch = (i == 0);
      tick();
      if (prev_motor && !vif.motor_on && fall_i < 0) fall_i = i;
      if (!prev_fault && vif.fault && rise_i < 0) rise_i = i;
      prev_motor = vif.motor_on;
      prev_fault = vif.fault;
    end
    check("flt_delay", 32'(rise_i - fall_i), 16);
    check("flt_fault", 32'(vif.fault), 1);
    check("flt_stock", 32'(vif.stock_count), 10);
    vif.can_despatch = 1'b1;
    tick();
    vif.can_despatch = 1'b0;
    check("flt_pending_accum", 32'(vif.pending), 1);
    tick();
    check("flt_pending_held", 32'(vif.pending), 1);
    check("flt_motor_off", 32'(vif.motor_on), 0);
    vif.fault_clr = 1'b1;
    tick();
    vif.fault_clr = 1'b0;
    check("flt_cleared", 32'(vif.fault), 0);
    tick();
    check("flt_resume_motor", 32'(vif.motor_on), 1);
    check("flt_resume_pending", 32'(vif.pending), 0);
    for (int i = 0; i < 8; i++) tick();
    check("flt_resume_motor_off", 32'(vif.motor_on), 0);
    vif.drop_sensor = 1'b1;
    tick();
    vif.drop_sensor = 1'b0;
    check("flt_resume_item", 32'(vif.item_out), 1);
    tick();
    check("flt_resume_stock", 32'(vif.stock_count), 9);

    // drain stock to zero, then requests with no stock
    do_reset();
    vif.drop_sensor = 1'b1;
    items = 0;
    for (int v = 0; v < 10; v++) begin
      vif.can_despatch = 1'b1;
      tick();
      vif.can_despatch = 1'b0;
      if (vif.item_out) items++;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (vif.item_out) items++;
      end
    end
    vif.drop_sensor = 1'b0;
    check("empty_items", 32'(items), 10);
    check("empty_stock", 32'(vif.stock_count), 0);
    check("empty_flag", 32'(vif.stock_empty), 1);
    on_cnt = 0; ref_cnt = 0; peak = 0;
    for (int i = 0; i < 8; i++) begin
      vif.can_despatch = (i == 0 || i == 2);
      tick();
      if (vif.motor_on) on_cnt++;
      if (int'(vif.pending) > peak) peak = int'(vif.pending);
`ifdef VEND_REFUND_EN
      if (vif.refund) ref_cnt++;
`endif
    end
    check("empty_no_motor", 32'(on_cnt), 0);
    check("empty_peak_pending", 32'(peak), 1);
    check("empty_pending_drained", 32'(vif.pending), 0);
`ifdef VEND_REFUND_EN
    check("empty_refunds", 32'(ref_cnt), 2);
`endif
    vif.refill = 1'b1;
    tick();
    vif.refill = 1'b0;
    check("refill_stock", 32'(vif.stock_count), 10);
    check("refill_empty", 32'(vif.stock_empty), 0);

    // saturation at 7, then refill coincident with DONE
    do_reset();
    for (int i = 0; i < 21; i++) begin
      vif.can_despatch = (i % 2 == 0) && (i <= 18);
      tick();
    end
    check("sat_pending", 32'(vif.pending), 7);
    check("sat_fault_not_yet", 32'(vif.fault), 0);
    vif.drop_sensor = 1'b1;
    tick();
    vif.drop_sensor = 1'b0;
    check("sat_done_item", 32'(vif.item_out), 1);
    vif.refill = 1'b1;
    tick();
    vif.refill = 1'b0;
    check("refill_over_done", 32'(vif.stock_count), 10);
    check("sat_pending_after", 32'(vif.pending), 7);

    // level held high counts once, then reset during MOTOR
    do_reset();
    for (int i = 0; i < 5; i++) begin
      vif.can_despatch = 1'b1;
      tick();
      if (i == 0) check("hold_first_pending", 32'(vif.pending), 1);
    end
    check("hold_pending", 32'(vif.pending), 0);
    check("hold_motor", 32'(vif.motor_on), 1);
    vif.can_despatch = 1'b0;
    tick();
    vif.can_despatch = 1'b1;
    tick();
    vif.can_despatch = 1'b0;
    check("mid_pending", 32'(vif.pending), 1);
    rst = 1'b1;
    tick();
    check("midrst_motor", 32'(vif.motor_on), 0);
    check("midrst_pending", 32'(vif.pending), 0);
    check("midrst_stock", 32'(vif.stock_count), 10);
    rst = 1'b0;
    tick();
    check("midrst_idle", 32'(vif.motor_on), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
